// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode/funct constants, ALU codes, state and mux encodings for multicycle_ctrl
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_NOOP    = 6'b000000;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SLT     = 6'b101010;

  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_XOR = 6'b100110;
  localparam logic [5:0] ALU_SLT = 6'b101010;
  localparam logic [5:0] ALU_NOP = 6'b101100;

  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_REGA   = 2'd3;

  typedef struct packed {
    logic   known;
    state_t nxt;
  } dispatch_t;

  // Instruction dispatch out of DECODE; known=0 flags an illegal opcode/funct.
  function automatic dispatch_t dispatch(input logic [5:0] op, input logic [5:0] fn);
    dispatch_t d;
    d.known = 1'b1;
    d.nxt   = S_FETCH;
    case (op)
      OP_LW, OP_SW: d.nxt = S_MEMADR;
      OP_XORI:      d.nxt = S_EXEC;
      OP_BNE:       d.nxt = S_BRANCH;
      OP_J, OP_JAL: d.nxt = S_JUMP;
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_SLT: d.nxt = S_EXEC;
          FN_JR:                  d.nxt = S_JUMP;
          FN_SYSCALL:             d.nxt = S_HALT;
          FN_NOOP:                d.nxt = S_FETCH;
          default:                d.known = 1'b0;
        endcase
      end
      default: d.known = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - consecutive memory wait-cycle counter; expired flags the final allowed wait cycle
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign expired = count_en && (r_count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM; define MULTICYCLE_CTRL_TIMEOUT_EN for the memory-wait watchdog
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  input  logic       alu_zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic       WriDataSel,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [5:0] ALUOp,
  output logic [3:0] state,
  output logic       halt,
  output logic       err
);

  state_t    r_state;
  state_t    w_next;
  dispatch_t w_dispatch;

  assign w_dispatch = dispatch(opcode, funct);
  assign state      = r_state;

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
  logic w_wait_state;
  logic w_count_en;
  logic w_clear;
  logic w_expired;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_count_en   = w_wait_state && !mem_ready;
  // Expiry in FETCH does not change state, so it must clear the count explicitly.
  assign w_clear      = (w_next != r_state) || w_expired;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mem_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_clear),
    .count_en (w_count_en),
    .expired  (w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    ALUSrcA    = 1'b0;
    WriDataSel = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSource   = PCS_ALU;
    ALUOp      = ALU_NOP;
    halt       = 1'b0;
    err        = 1'b0;

    // While reset is high every output stays at its idle value so no access or write can start.
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          ALUOp   = ALU_ADD;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          if (mem_ready) w_next = S_DECODE;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMMSH;
          ALUOp   = ALU_ADD;
          w_next  = w_dispatch.nxt;
          err     = !w_dispatch.known;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_ADD;
          w_next  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) w_next = S_MEMWB;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          WriDataSel = 1'b1;
          w_next     = S_FETCH;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (mem_ready) w_next = S_FETCH;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          if (opcode == OP_XORI) begin
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALU_XOR;
          end else begin
            ALUSrcB = SRCB_REG;
            ALUOp   = funct;
          end
          w_next = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          WriDataSel = 1'b1;
          w_next     = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = SRCB_REG;
          ALUOp    = ALU_SUB;
          PCSource = PCS_ALUOUT;
          PCWrite  = !alu_zero;
          w_next   = S_FETCH;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = ((opcode == OP_RTYPE) && (funct == FN_JR)) ? PCS_REGA : PCS_JUMP;
          if (opcode == OP_JAL) begin
            RegWrite   = 1'b1;
            WriDataSel = 1'b0;
          end
          w_next = S_FETCH;
        end
        S_HALT: begin
          halt   = 1'b1;
          w_next = S_HALT;
        end
        default: w_next = S_FETCH;
      endcase

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
      if (w_expired) begin
        w_next   = S_FETCH;
        err      = 1'b1;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl (watchdog checks when MULTICYCLE_CTRL_TIMEOUT_EN is defined)
module tb_multicycle_ctrl;

  localparam logic [5:0] O_R    = 6'b000000;
  localparam logic [5:0] O_J    = 6'b000010;
  localparam logic [5:0] O_JAL  = 6'b000011;
  localparam logic [5:0] O_BNE  = 6'b000101;
  localparam logic [5:0] O_XORI = 6'b001110;
  localparam logic [5:0] O_LW   = 6'b100011;
  localparam logic [5:0] O_SW   = 6'b101011;
  localparam logic [5:0] O_BAD  = 6'b111111;

  localparam logic [5:0] F_NOOP = 6'b000000;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_SYS  = 6'b001100;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [5:0] A_ADD = 6'b100000;
  localparam logic [5:0] A_SUB = 6'b100010;
  localparam logic [5:0] A_XOR = 6'b100110;
  localparam logic [5:0] A_NOP = 6'b101100;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, iord, mrd, mwr, m2r, rw, rdst, asa, wds;
    logic [1:0] asb, pcs;
    logic [5:0] aop;
    logic       hlt, er;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       mem_ready, alu_zero;
  logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, MemtoReg, RegWrite, RegDst, ALUSrcA, WriDataSel;
  logic [1:0] ALUSrcB, PCSource;
  logic [5:0] ALUOp;
  logic [3:0] state;
  logic       halt, err;

  int   total = 0;
  int   bad   = 0;
  obs_t exp_q[$];
  string name_q[$];

  multicycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .alu_zero(alu_zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
    .ALUSrcA(ALUSrcA), .WriDataSel(WriDataSel), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .state(state), .halt(halt), .err(err)
  );

  always #5 clk = ~clk;

  function automatic obs_t idle(input logic [3:0] s);
    obs_t o;
    o = '0; o.st = s; o.aop = A_NOP;
    return o;
  endfunction

  function automatic obs_t e_fetch(input logic mr);
    obs_t o;
    o = idle(4'd0); o.mrd = 1'b1; o.asb = 2'd1; o.aop = A_ADD; o.irw = mr; o.pcw = mr;
    return o;
  endfunction

  function automatic obs_t e_decode(input logic e);
    obs_t o;
    o = idle(4'd1); o.asb = 2'd3; o.aop = A_ADD; o.er = e;
    return o;
  endfunction

  function automatic obs_t e_memadr();
    obs_t o;
    o = idle(4'd2); o.asa = 1'b1; o.asb = 2'd2; o.aop = A_ADD;
    return o;
  endfunction

  function automatic obs_t e_memrd();
    obs_t o;
    o = idle(4'd3); o.mrd = 1'b1; o.iord = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_memwb();
    obs_t o;
    o = idle(4'd4); o.rw = 1'b1; o.m2r = 1'b1; o.wds = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_memwr();
    obs_t o;
    o = idle(4'd5); o.mwr = 1'b1; o.iord = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_exec(input logic [5:0] a, input logic [1:0] b);
    obs_t o;
    o = idle(4'd6); o.asa = 1'b1; o.asb = b; o.aop = a;
    return o;
  endfunction

  function automatic obs_t e_aluwb();
    obs_t o;
    o = idle(4'd7); o.rw = 1'b1; o.rdst = 1'b1; o.wds = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_branch(input logic p);
    obs_t o;
    o = idle(4'd8); o.asa = 1'b1; o.aop = A_SUB; o.pcs = 2'd1; o.pcw = p;
    return o;
  endfunction

  function automatic obs_t e_jump(input logic [1:0] p, input logic link);
    obs_t o;
    o = idle(4'd9); o.pcw = 1'b1; o.pcs = p; o.rw = link;
    return o;
  endfunction

  function automatic obs_t e_halt();
    obs_t o;
    o = idle(4'd10); o.hlt = 1'b1;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.st = state; o.pcw = PCWrite; o.irw = IRWrite; o.iord = IorD; o.mrd = MemRead;
    o.mwr = MemWrite; o.m2r = MemtoReg; o.rw = RegWrite; o.rdst = RegDst; o.asa = ALUSrcA;
    o.wds = WriDataSel; o.asb = ALUSrcB; o.pcs = PCSource; o.aop = ALUOp; o.hlt = halt; o.er = err;
    return o;
  endfunction

  task automatic step(input string nm, input logic [5:0] op, input logic [5:0] fn,
                      input logic mr, input logic az, input obs_t e);
    opcode = op; funct = fn; mem_ready = mr; alu_zero = az;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string nm, input logic [5:0] op, input logic [5:0] fn, input logic e);
    step({nm, "_fetch"}, op, fn, 1'b1, 1'b0, e_fetch(1'b1));
    step({nm, "_decode"}, op, fn, 1'b0, 1'b0, e_decode(e));
  endtask

  task automatic run_alu(input string nm, input logic [5:0] op, input logic [5:0] fn,
                         input logic [5:0] a, input logic [1:0] b);
    fetch_decode(nm, op, fn, 1'b0);
    step({nm, "_exec"}, op, fn, 1'b0, 1'b0, e_exec(a, b));
    step({nm, "_aluwb"}, op, fn, 1'b0, 1'b0, e_aluwb());
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle on the falling edge.
  initial begin
    obs_t a, e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = observe();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s actual=%h required=%h", nm, a, e);
        end
      end
    end
  end

  initial begin
    obs_t e;
    reset = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b1; alu_zero = 1'b0;
    @(posedge clk);
    #1;
    step("reset_idle0", O_R, F_ADD, 1'b1, 1'b0, idle(4'd0));
    step("reset_idle1", O_LW, 6'd0, 1'b1, 1'b0, idle(4'd0));
    reset = 1'b0;

    step("add_fetch_wait", O_R, F_ADD, 1'b0, 1'b0, e_fetch(1'b0));
    run_alu("add", O_R, F_ADD, A_ADD, 2'd0);
    run_alu("sub", O_R, F_SUB, A_SUB, 2'd0);
    run_alu("slt", O_R, F_SLT, F_SLT, 2'd0);
    run_alu("xori", O_XORI, 6'b010101, A_XOR, 2'd2);

    fetch_decode("lw", O_LW, 6'd0, 1'b0);
    step("lw_memadr", O_LW, 6'd0, 1'b0, 1'b0, e_memadr());
    for (int i = 0; i < 3; i++) step("lw_memrd_wait", O_LW, 6'd0, 1'b0, 1'b0, e_memrd());
    step("lw_memrd_done", O_LW, 6'd0, 1'b1, 1'b0, e_memrd());
    step("lw_memwb", O_LW, 6'd0, 1'b0, 1'b0, e_memwb());

    fetch_decode("sw", O_SW, 6'd0, 1'b0);
    step("sw_memadr", O_SW, 6'd0, 1'b0, 1'b0, e_memadr());
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step("sw_memwr_wait", O_SW, 6'd0, 1'b0, 1'b0, e_memwr());
    e = e_memwr(); e.er = 1'b1;
    step("sw_memwr_expire", O_SW, 6'd0, 1'b0, 1'b0, e);
    step("sw_after_expire", O_SW, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));

    fetch_decode("lwrace", O_LW, 6'd0, 1'b0);
    step("lwrace_memadr", O_LW, 6'd0, 1'b0, 1'b0, e_memadr());
    for (int i = 0; i < 15; i++) step("lwrace_wait", O_LW, 6'd0, 1'b0, 1'b0, e_memrd());
    step("lwrace_ready_on_expiry", O_LW, 6'd0, 1'b1, 1'b0, e_memrd());
    step("lwrace_memwb", O_LW, 6'd0, 1'b0, 1'b0, e_memwb());

    for (int i = 0; i < 15; i++) step("fetch_to_wait", O_R, F_NOOP, 1'b0, 1'b0, e_fetch(1'b0));
    e = e_fetch(1'b0); e.er = 1'b1;
    step("fetch_to_expire", O_R, F_NOOP, 1'b0, 1'b0, e);
    step("fetch_to_cleared", O_R, F_NOOP, 1'b0, 1'b0, e_fetch(1'b0));
`else
    for (int i = 0; i < 20; i++) step("sw_memwr_hold", O_SW, 6'd0, 1'b0, 1'b0, e_memwr());
    step("sw_memwr_done", O_SW, 6'd0, 1'b1, 1'b0, e_memwr());
`endif

    fetch_decode("bne_taken_not", O_BNE, 6'd3, 1'b0);
    step("bne_zero", O_BNE, 6'd3, 1'b0, 1'b1, e_branch(1'b0));
    fetch_decode("bne_taken", O_BNE, 6'd3, 1'b0);
    step("bne_nonzero", O_BNE, 6'd3, 1'b0, 1'b0, e_branch(1'b1));

    fetch_decode("jal", O_JAL, 6'd7, 1'b0);
    step("jal_jump", O_JAL, 6'd7, 1'b0, 1'b0, e_jump(2'd2, 1'b1));
    fetch_decode("j", O_J, 6'd7, 1'b0);
    step("j_jump", O_J, 6'd7, 1'b0, 1'b0, e_jump(2'd2, 1'b0));
    fetch_decode("jr", O_R, F_JR, 1'b0);
    step("jr_jump", O_R, F_JR, 1'b0, 1'b0, e_jump(2'd3, 1'b0));

    fetch_decode("noop", O_R, F_NOOP, 1'b0);
    fetch_decode("badop", O_BAD, F_ADD, 1'b1);
    fetch_decode("badfn", O_R, F_XOR, 1'b1);
    step("badfn_back_fetch", O_R, F_XOR, 1'b0, 1'b0, e_fetch(1'b0));

    fetch_decode("sw_rst", O_SW, 6'd0, 1'b0);
    step("sw_rst_memadr", O_SW, 6'd0, 1'b0, 1'b0, e_memadr());
    step("sw_rst_memwr", O_SW, 6'd0, 1'b0, 1'b0, e_memwr());
    reset = 1'b1;
    step("sw_rst_abandon", O_SW, 6'd0, 1'b1, 1'b0, idle(4'd0));
    reset = 1'b0;

    fetch_decode("sys", O_R, F_SYS, 1'b0);
    for (int i = 0; i < 20; i++) step("halt_hold", O_LW, 6'd0, 1'(i % 2), 1'b0, e_halt());
    reset = 1'b1;
    step("halt_async_reset", O_R, F_ADD, 1'b1, 1'b0, idle(4'd0));
    reset = 1'b0;
    fetch_decode("post_reset", O_R, F_ADD, 1'b0);

    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench time limit");
  end

endmodule
